popcount_ternary_neuron: RTL and testbench
==========================================

# popcount_ternary_neuron

Sequential ternary-neuron back end that consumes the 5-bit counts produced by a pair of 23-input approximate popcount units: one for positive-weight inputs, one for negative-weight inputs. It accumulates the signed difference over NCHUNK input chunks, so neurons with fan-in above 23 reuse one popcount pair serially. It then thresholds the total into a ternary activation {-1, 0, +1} and holds it under a valid/ready handshake for the next layer.

## Interface
Parameters:
- NCHUNK, default 4: beats per neuron evaluation, ≥1.
- PCW, default 5: popcount input width.
- ACCW, default derived as clog2((2^PCW-1)*NCHUNK+1)+1 (8 for the defaults): signed accumulator width.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  block can accept a beat.
- pos_cnt  in  PCW  unsigned count of the positive-weight chunk.
- neg_cnt  in  PCW  unsigned count of the negative-weight chunk.
- thr_hi  in  ACCW  signed upper threshold.
- thr_lo  in  ACCW  signed lower threshold.
- out_valid  out  1  activation valid.
- out_ready  in  1  downstream accepts the activation.
- out_act  out  2  activation: 2'b01 = +1, 2'b11 = -1, 2'b00 = 0.
- out_sum  out  ACCW  signed final sum, for debug and verification.

## Operation
- Two states: ACC and HOLD.
- ACC:
  - in_ready = 1, out_valid = 0.
  - A beat is accepted when in_valid && in_ready.
  - Each accepted beat adds d = zext(pos_cnt) - zext(neg_cnt). d lies in the range -(2^PCW-1) to +(2^PCW-1).
  - The beat counter cnt runs 0..NCHUNK-1.
- Final beat (cnt == NCHUNK-1 on acceptance):
  - sum = acc + d, computed in ACCW bits. Overflow cannot occur by construction.
  - Thresholds are sampled in the same cycle.
  - out_act is set to +1 if sum > thr_hi, otherwise -1 if sum < thr_lo, otherwise 0. +1 has priority when thr_lo > thr_hi.
  - out_sum is set to sum.
  - acc and cnt are cleared, and the state moves to HOLD.
- Non-final beat: acc += d, cnt++, state stays ACC.
- HOLD:
  - out_valid = 1, in_ready = 0.
  - out_act and out_sum are stable until out_valid && out_ready, then the state returns to ACC.
  - Thresholds changing during HOLD have no effect.
- NCHUNK = 1: every accepted beat is final.
- in_valid is ignored while in_ready = 0, and pos_cnt/neg_cnt are ignored without valid.
- Inputs are treated as arbitrary 0..2^PCW-1. Values above 23 from the approximate counter are accepted unchanged, with no clamping.

## Timing
- Reset values: state ACC, acc = 0, cnt = 0, out_valid = 0, out_act = 2'b00, out_sum = 0, in_ready = 1 starting from the first cycle after rst is sampled high.
- rst asserted mid-accumulation or during HOLD aborts the operation. The partial sum and pending output are discarded, with no output handshake.
- Latency: out_valid rises in the cycle after the final beat is accepted.
- Throughput: one neuron per NCHUNK+1 cycles when out_ready is held high, because HOLD costs one cycle.
- in_ready and out_valid are registered-state decodes with no combinational path from out_ready. The only exception is the HOLD→ACC transition, which takes effect in the next cycle.
- A bubble (in_valid = 0) in ACC leaves acc and cnt unchanged.

## Structure
- Shared package ternary_pkg holds:
  - the activation encodings ACT_POS = 2'b01, ACT_NEG = 2'b11, ACT_ZERO = 2'b00;
  - the state enum {ACC, HOLD};
  - a function acc_width(pcw, nchunk) returning the ACCW formula.
- One natural sub-module, ternary_threshold: purely combinational; takes sum, thr_hi and thr_lo and produces the 2-bit activation, applying the priority rule.
- Everything else lives in a single module: counter, accumulator, FSM and output registers.

## Test plan
- NCHUNK = 4, thr_hi = 3, thr_lo = -3; beats (pos, neg) = (10,2), (5,5), (0,7), (1,0) → sum = 2; out_act = 00 and out_valid asserted one cycle after the 4th beat.
- Same thresholds; four beats of (31,0) → out_sum = 124, out_act = 01. Four beats of (0,31) → out_sum = -124, out_act = 11. These verify there is no overflow at ACCW = 8.
- Backpressure: out_ready = 0 for 5 cycles in HOLD → in_ready = 0, and out_act/out_sum stay stable even with in_valid = 1 and thresholds toggling. After out_ready pulses high, the next beat is accepted the following cycle.
- Bubbles: in_valid deasserted between beats 2 and 3 for 3 cycles → same result as without bubbles; cnt and acc are not advanced.
- Reset mid-operation: rst asserted after 2 beats, then 4 beats of (4,0) → out_sum = 16, so there is no residue from the aborted neuron. rst asserted in HOLD → out_valid = 0 in the next cycle.
- thr_lo = 5, thr_hi = 2, sum = 1 → out_act = 11. sum = 3 → out_act = 01, demonstrating +1 priority. NCHUNK = 1 build: each beat produces an output after one cycle.

Source files
------------

// File: rtl/ternary_pkg.sv
// Shared definitions for the ternary popcount neuron: activation codes, FSM states
// and the accumulator width rule.
package ternary_pkg;

    localparam logic [1:0] ACT_POS  = 2'b01;
    localparam logic [1:0] ACT_NEG  = 2'b11;
    localparam logic [1:0] ACT_ZERO = 2'b00;

    typedef enum logic {ACC, HOLD} state_e;

    // Enough bits for +/-(2^pcw-1)*nchunk plus a sign bit.
    function automatic int unsigned acc_width(int unsigned pcw, int unsigned nchunk);
        return $clog2(((2 ** pcw) - 1) * nchunk + 1) + 1;
    endfunction

endpackage

// File: rtl/ternary_threshold.sv
// Combinational ternary threshold: +1 above thr_hi, -1 below thr_lo, else 0.
module ternary_threshold
    import ternary_pkg::*;
#(
    parameter int unsigned ACCW = 8
) (
    input  logic signed [ACCW-1:0] sum,
    input  logic signed [ACCW-1:0] thr_hi,
    input  logic signed [ACCW-1:0] thr_lo,
    output logic        [1:0]      act
);

    // +1 is tested first so it wins when the thresholds are inverted.
    always_comb begin
        act = ACT_ZERO;
        if (sum > thr_hi) begin
            act = ACT_POS;
        end else if (sum < thr_lo) begin
            act = ACT_NEG;
        end
    end

endmodule

// File: rtl/popcount_ternary_neuron.sv
// Serial ternary neuron: accumulates pos-neg popcount differences over NCHUNK beats,
// thresholds the total and holds the activation under a valid/ready handshake.
module popcount_ternary_neuron
    import ternary_pkg::*;
#(
    parameter int unsigned NCHUNK = 4,
    parameter int unsigned PCW    = 5,
    parameter int unsigned ACCW   = acc_width(PCW, NCHUNK)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic        [PCW-1:0]  pos_cnt,
    input  logic        [PCW-1:0]  neg_cnt,
    input  logic signed [ACCW-1:0] thr_hi,
    input  logic signed [ACCW-1:0] thr_lo,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic        [1:0]      out_act,
    output logic signed [ACCW-1:0] out_sum
);

    localparam int unsigned    CNTW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNTW-1:0] LAST = CNTW'(NCHUNK - 1);

    state_e                 state;
    logic        [CNTW-1:0] cnt;
    logic signed [ACCW-1:0] acc;
    logic signed [ACCW-1:0] d;
    logic signed [ACCW-1:0] sum_next;
    logic        [1:0]      act_next;
    logic                   accept;

    // Zero-extend both counts before subtracting; the result is a signed difference.
    assign d        = ACCW'(pos_cnt) - ACCW'(neg_cnt);
    assign sum_next = acc + d;
    assign accept   = in_valid && (state == ACC);

    assign in_ready  = (state == ACC);
    assign out_valid = (state == HOLD);

    ternary_threshold #(
        .ACCW (ACCW)
    ) u_threshold (
        .sum    (sum_next),
        .thr_hi (thr_hi),
        .thr_lo (thr_lo),
        .act    (act_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ACC;
            cnt     <= '0;
            acc     <= '0;
            out_act <= ACT_ZERO;
            out_sum <= '0;
        end else begin
            case (state)
                ACC: begin
                    if (accept) begin
                        if (cnt == LAST) begin
                            out_act <= act_next;
                            out_sum <= sum_next;
                            acc     <= '0;
                            cnt     <= '0;
                            state   <= HOLD;
                        end else begin
                            acc <= sum_next;
                            cnt <= cnt + CNTW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state <= ACC;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_popcount_ternary_neuron.sv
// Scoreboard bench: one NCHUNK=4 neuron and one NCHUNK=1 neuron driven with directed beats.
module tb_popcount_ternary_neuron;

    typedef struct {
        logic [1:0] act;
        int         sum;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // NCHUNK = 4 instance (ACCW = 8)
    logic              a_rst = 1'b1, a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b1;
    logic        [4:0] a_pos = '0, a_neg = '0;
    logic signed [7:0] a_thr_hi = 8'sd3, a_thr_lo = -8'sd3, a_out_sum;
    logic        [1:0] a_out_act;

    // NCHUNK = 1 instance (ACCW = 6)
    logic              b_rst = 1'b1, b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1;
    logic        [4:0] b_pos = '0, b_neg = '0;
    logic signed [5:0] b_thr_hi = 6'sd3, b_thr_lo = -6'sd3, b_out_sum;
    logic        [1:0] b_out_act;

    exp_t qa[$];
    exp_t qb[$];

    popcount_ternary_neuron #(.NCHUNK(4), .PCW(5)) dut_a (
        .clk (clk), .rst (a_rst), .in_valid (a_in_valid), .in_ready (a_in_ready),
        .pos_cnt (a_pos), .neg_cnt (a_neg), .thr_hi (a_thr_hi), .thr_lo (a_thr_lo),
        .out_valid (a_out_valid), .out_ready (a_out_ready), .out_act (a_out_act),
        .out_sum (a_out_sum)
    );

    popcount_ternary_neuron #(.NCHUNK(1), .PCW(5)) dut_b (
        .clk (clk), .rst (b_rst), .in_valid (b_in_valid), .in_ready (b_in_ready),
        .pos_cnt (b_pos), .neg_cnt (b_neg), .thr_hi (b_thr_hi), .thr_lo (b_thr_lo),
        .out_valid (b_out_valid), .out_ready (b_out_ready), .out_act (b_out_act),
        .out_sum (b_out_sum)
    );

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Monitors: pop and compare whenever an output handshake is about to happen.
    always @(negedge clk) begin
        if (!a_rst && a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_output", 1, 0);
            end else begin
                exp_t e;
                e = qa.pop_front();
                chk("a_out_act", int'(a_out_act), int'(e.act));
                chk("a_out_sum", int'(a_out_sum), e.sum);
            end
        end
        if (!b_rst && b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_output", 1, 0);
            end else begin
                exp_t e;
                e = qb.pop_front();
                chk("b_out_act", int'(b_out_act), int'(e.act));
                chk("b_out_sum", int'(b_out_sum), e.sum);
            end
        end
    end

    // Present one beat to A and wait (bounded) for it to be accepted.
    task automatic beat_a(input int p, input int n);
        bit done = 0;
        a_pos      = 5'(p);
        a_neg      = 5'(n);
        a_in_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            done = a_in_ready;
            @(posedge clk);
        end
        #1;
        a_in_valid = 1'b0;
        if (!done) chk("a_beat_timeout", 0, 1);
    endtask

    task automatic beat_b(input int p, input int n);
        bit done = 0;
        b_pos      = 5'(p);
        b_neg      = 5'(n);
        b_in_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            done = b_in_ready;
            @(posedge clk);
        end
        #1;
        b_in_valid = 1'b0;
        if (!done) chk("b_beat_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic neuron_a(input int p, input int n, input logic [1:0] act, input int sum);
        qa.push_back('{act, sum});
        repeat (4) beat_a(p, n);
        idle(1);
    endtask

    initial begin
        idle(2);
        a_rst = 1'b0;
        b_rst = 1'b0;

        chk("reset_in_ready",  int'(a_in_ready), 1);
        chk("reset_out_valid", int'(a_out_valid), 0);
        chk("reset_out_act",   int'(a_out_act), 0);
        chk("reset_out_sum",   int'(a_out_sum), 0);

        // 8 + 0 - 7 + 1 = 2, inside [-3, 3]
        qa.push_back('{2'b00, 2});
        beat_a(10, 2); beat_a(5, 5); beat_a(0, 7);
        chk("no_valid_before_last", int'(a_out_valid), 0);
        beat_a(1, 0);
        chk("latency_out_valid", int'(a_out_valid), 1);
        idle(1);

        neuron_a(31, 0, 2'b01, 124);
        neuron_a(0, 31, 2'b11, -124);

        // Backpressure: 4 * 3 = 12 held while thresholds and inputs churn
        a_out_ready = 1'b0;
        qa.push_back('{2'b01, 12});
        repeat (4) beat_a(3, 0);
        a_in_valid = 1'b1;
        a_pos      = 5'd31;
        for (int i = 0; i < 5; i++) begin
            a_thr_hi = (i % 2 == 0) ? 8'sd100 : -8'sd100;
            a_thr_lo = (i % 2 == 0) ? 8'sd90  : -8'sd110;
            idle(1);
            chk("hold_in_ready", int'(a_in_ready), 0);
            chk("hold_out_act",  int'(a_out_act), 1);
            chk("hold_out_sum",  int'(a_out_sum), 12);
        end
        a_in_valid  = 1'b0;
        a_thr_hi    = 8'sd3;
        a_thr_lo    = -8'sd3;
        a_out_ready = 1'b1;
        idle(1);
        chk("release_in_ready", int'(a_in_ready), 1);
        neuron_a(2, 1, 2'b01, 4);

        // Bubbles between beats 2 and 3
        qa.push_back('{2'b00, 2});
        beat_a(10, 2); beat_a(5, 5);
        idle(3);
        beat_a(0, 7); beat_a(1, 0);
        idle(1);

        // Reset after two beats discards the partial sum
        beat_a(9, 0); beat_a(9, 0);
        a_rst = 1'b1;
        idle(1);
        a_rst = 1'b0;
        neuron_a(4, 0, 2'b01, 16);

        // Reset during HOLD drops the pending output
        a_out_ready = 1'b0;
        repeat (4) beat_a(1, 0);
        chk("hold_before_reset", int'(a_out_valid), 1);
        a_rst = 1'b1;
        idle(1);
        a_rst = 1'b0;
        chk("reset_in_hold_out_valid", int'(a_out_valid), 0);
        a_out_ready = 1'b1;

        // Inverted thresholds: +1 has priority
        a_thr_lo = 8'sd5;
        a_thr_hi = 8'sd2;
        qa.push_back('{2'b11, 1});
        beat_a(1, 0); beat_a(0, 0); beat_a(0, 0); beat_a(0, 0);
        idle(1);
        qa.push_back('{2'b01, 3});
        beat_a(3, 0); beat_a(0, 0); beat_a(0, 0); beat_a(0, 0);
        idle(1);

        // NCHUNK = 1: every beat is final
        qb.push_back('{2'b01, 31});
        beat_b(31, 0);
        chk("b_latency", int'(b_out_valid), 1);
        idle(1);
        qb.push_back('{2'b11, -31});
        beat_b(0, 31);
        idle(1);
        qb.push_back('{2'b00, 0});
        beat_b(2, 2);
        idle(1);
        qb.push_back('{2'b00, 3});
        beat_b(20, 17);
        idle(1);

        idle(3);
        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
